// File: rtl/stage_type_streamer.sv
// -----------------------------------------------------------------------------
// stage_type_streamer
//
// Takes the five 2-character ASCII instruction-type strings (IF, ID, EX, MEM,
// WB) from the per-stage type decoders and captures all five in one cycle. It
// then streams a fixed 20-character frame to the character-LCD writer over a
// valid/ready handshake.
//
// Frame layout: four columns per stage, in the order IF, ID, EX, MEM, WB:
//   <letter> ':' <pair[15:8]> <pair[7:0]>
// The letters are F, D, E, M, W. For example: "F:01D:02E:08M:11W:xx".
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   type_if     in   [15:0] IF-stage ASCII pair, [15:8] is the leftmost char
//   type_id     in   [15:0] ID-stage ASCII pair
//   type_ex     in   [15:0] EX-stage ASCII pair
//   type_mem    in   [15:0] MEM-stage ASCII pair
//   type_wb     in   [15:0] WB-stage ASCII pair
//   snap        in   one-cycle frame request
//   char_data   out  [7:0] ASCII character for column char_addr
//   char_addr   out  [4:0] LCD column 0..19
//   char_valid  out  char_data/char_addr valid
//   char_ready  in   writer accepts the current character
//   busy        out  high while a frame is being sent or finishing
//   frame_done  out  one-cycle pulse at frame end
//
// Parameter
//   REFRESH     cycles between automatic frame triggers; 0 disables them
// -----------------------------------------------------------------------------
module stage_type_streamer #(
  parameter int unsigned REFRESH = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] type_if,
  input  logic [15:0] type_id,
  input  logic [15:0] type_ex,
  input  logic [15:0] type_mem,
  input  logic [15:0] type_wb,
  input  logic        snap,
  output logic [7:0]  char_data,
  output logic [4:0]  char_addr,
  output logic        char_valid,
  input  logic        char_ready,
  output logic        busy,
  output logic        frame_done
);

  // Refresh counter sizing. Keep at least one bit so that REFRESH of 0 or 1
  // still elaborates cleanly.
  localparam int unsigned CNT_W = (REFRESH > 32'd1) ? $clog2(REFRESH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((REFRESH == 32'd0) ? 32'd0 : (REFRESH - 32'd1));

  localparam logic [4:0]  LAST_COL  = 5'd19;
  localparam logic [15:0] SNAP_INIT = 16'h2D2D;   // "--"
  localparam logic [7:0]  COLON     = 8'h3A;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [4:0]       r_idx;
  logic             r_pending;
  logic             r_char_valid;
  logic             r_busy;
  logic             r_frame_done;
  logic [15:0]      r_snap_if;
  logic [15:0]      r_snap_id;
  logic [15:0]      r_snap_ex;
  logic [15:0]      r_snap_mem;
  logic [15:0]      r_snap_wb;
  logic [CNT_W-1:0] r_refresh_cnt;

  logic             w_tick;
  logic             w_request;
  logic             w_trigger;
  logic [7:0]       w_char;

  // Selects the frame character for a given column from the snapshot.
  // Columns above 19 never occur while streaming; they map to 0.
  function automatic logic [7:0] frame_char(
    input logic [4:0]  idx,
    input logic [15:0] s_if,
    input logic [15:0] s_id,
    input logic [15:0] s_ex,
    input logic [15:0] s_mem,
    input logic [15:0] s_wb
  );
    logic [15:0] pair;
    logic [7:0]  letter;
    logic [7:0]  ch;
    case (idx[4:2])
      3'd0:    begin pair = s_if;  letter = 8'h46; end  // 'F'
      3'd1:    begin pair = s_id;  letter = 8'h44; end  // 'D'
      3'd2:    begin pair = s_ex;  letter = 8'h45; end  // 'E'
      3'd3:    begin pair = s_mem; letter = 8'h4D; end  // 'M'
      3'd4:    begin pair = s_wb;  letter = 8'h57; end  // 'W'
      default: begin pair = 16'h0000; letter = 8'h00; end
    endcase
    case (idx[1:0])
      2'd0:    ch = letter;
      2'd1:    ch = COLON;
      2'd2:    ch = pair[15:8];
      2'd3:    ch = pair[7:0];
      default: ch = 8'h00;
    endcase
    if (idx[4:2] > 3'd4) begin
      ch = 8'h00;
    end else begin
      ch = ch;
    end
    return ch;
  endfunction

  // Tick when the free-running counter sits at its last value. No tick when
  // automatic refresh is disabled.
  always_comb begin
    w_tick = 1'b0;
    if (REFRESH != 32'd0) begin
      w_tick = (r_refresh_cnt == CNT_LAST);
    end else begin
      w_tick = 1'b0;
    end
  end

  assign w_request = snap | w_tick;
  assign w_trigger = w_request | r_pending;

  // Free-running refresh counter. It runs in every FSM state and wraps after
  // the tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_refresh_cnt <= '0;
    end else if (w_tick) begin
      r_refresh_cnt <= '0;
    end else if (REFRESH != 32'd0) begin
      r_refresh_cnt <= r_refresh_cnt + CNT_W'(1);
    end
  end

  // Frame FSM. It owns the snapshot, the column index, the single-deep
  // pending request and the registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_idx        <= 5'd0;
      r_pending    <= 1'b0;
      r_char_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_snap_if    <= SNAP_INIT;
      r_snap_id    <= SNAP_INIT;
      r_snap_ex    <= SNAP_INIT;
      r_snap_mem   <= SNAP_INIT;
      r_snap_wb    <= SNAP_INIT;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_frame_done <= 1'b0;
          if (w_trigger) begin
            // Capture all five stages together so that the frame is a
            // coherent picture of a single pipeline cycle.
            r_snap_if    <= type_if;
            r_snap_id    <= type_id;
            r_snap_ex    <= type_ex;
            r_snap_mem   <= type_mem;
            r_snap_wb    <= type_wb;
            r_idx        <= 5'd0;
            r_pending    <= 1'b0;
            r_char_valid <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= S_SEND;
          end
        end
        S_SEND: begin
          // Requests that arrive mid-frame collapse into one follow-on frame.
          if (w_request) begin
            r_pending <= 1'b1;
          end
          if (r_char_valid && char_ready) begin
            if (r_idx == LAST_COL) begin
              r_char_valid <= 1'b0;
              r_frame_done <= 1'b1;
              r_state      <= S_DONE;
            end else begin
              r_idx <= r_idx + 5'd1;
            end
          end
        end
        S_DONE: begin
          if (w_request) begin
            r_pending <= 1'b1;
          end
          r_frame_done <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: begin
          r_char_valid <= 1'b0;
          r_busy       <= 1'b0;
          r_frame_done <= 1'b0;
          r_pending    <= 1'b0;
          r_idx        <= 5'd0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  // Character lookup. Forced to 0 outside SEND so that the bus reads 0
  // whenever char_valid is low, including during reset.
  always_comb begin
    w_char = 8'h00;
    if (r_char_valid) begin
      w_char = frame_char(r_idx, r_snap_if, r_snap_id, r_snap_ex,
                          r_snap_mem, r_snap_wb);
    end else begin
      w_char = 8'h00;
    end
  end

  assign char_data  = w_char;
  assign char_addr  = r_idx;
  assign char_valid = r_char_valid;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_stage_type_streamer.sv
// -----------------------------------------------------------------------------
// Testbench for stage_type_streamer. Two instances share the stimulus:
// - dut0 (REFRESH=0) carries the functional scenarios.
// - dut64 (REFRESH=64) carries the automatic-refresh cadence.
// Expected characters are pushed into a scoreboard queue when a frame is
// requested. A negedge monitor records what each DUT emits, and each test
// task pops and compares inline.
// -----------------------------------------------------------------------------
module tb_stage_type_streamer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        snap = 1'b0;
  logic        char_ready = 1'b1;
  logic [15:0] type_if = 16'h2020;
  logic [15:0] type_id = 16'h2020;
  logic [15:0] type_ex = 16'h2020;
  logic [15:0] type_mem = 16'h2020;
  logic [15:0] type_wb = 16'h2020;

  logic [7:0]  char_data;
  logic [4:0]  char_addr;
  logic        char_valid, busy, frame_done;
  logic [7:0]  d64_data;
  logic [4:0]  d64_addr;
  logic        d64_valid, d64_busy, d64_done;

  stage_type_streamer #(.REFRESH(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .type_if(type_if), .type_id(type_id),
    .type_ex(type_ex), .type_mem(type_mem), .type_wb(type_wb), .snap(snap),
    .char_data(char_data), .char_addr(char_addr), .char_valid(char_valid),
    .char_ready(char_ready), .busy(busy), .frame_done(frame_done)
  );

  stage_type_streamer #(.REFRESH(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .type_if(type_if), .type_id(type_id),
    .type_ex(type_ex), .type_mem(type_mem), .type_wb(type_wb), .snap(snap),
    .char_data(d64_data), .char_addr(d64_addr), .char_valid(d64_valid),
    .char_ready(char_ready), .busy(d64_busy), .frame_done(d64_done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] cyc;
    logic        rdy;
    logic        bsy;
    logic [4:0]  addr;
    logic [7:0]  data;
  } beat_t;

  beat_t       val_q[$];   // every cycle dut0 shows char_valid
  beat_t       obs_q[$];   // dut0 beats accepted (valid & ready)
  beat_t       st64_q[$];  // dut64 first beat of each frame
  int unsigned fd_q[$];
  int unsigned fd64_q[$];
  logic [12:0] sb_q[$];    // expected {addr, data}
  logic        v64_prev = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  // Monitor: record DUT activity away from the active edge.
  always @(negedge clk) begin
    if (char_valid) begin
      val_q.push_back({cyc, char_ready, busy, char_addr, char_data});
      if (char_ready) obs_q.push_back({cyc, char_ready, busy, char_addr, char_data});
    end
    if (frame_done) fd_q.push_back(cyc);
    if (d64_valid && !v64_prev) st64_q.push_back({cyc, char_ready, d64_busy, d64_addr, d64_data});
    if (d64_done) fd64_q.push_back(cyc);
    v64_prev <= d64_valid;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    val_q.delete(); obs_q.delete(); fd_q.delete(); sb_q.delete();
  endtask

  task automatic push_frame(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] d,
                            input logic [15:0] e);
    logic [15:0] s[5];
    logic [7:0]  l[5];
    s = '{a, b, c, d, e};
    l = '{8'h46, 8'h44, 8'h45, 8'h4D, 8'h57};
    for (int k = 0; k < 5; k++) begin
      sb_q.push_back({5'(4*k),     l[k]});
      sb_q.push_back({5'(4*k + 1), 8'h3A});
      sb_q.push_back({5'(4*k + 2), s[k][15:8]});
      sb_q.push_back({5'(4*k + 3), s[k][7:0]});
    end
  endtask

  task automatic wait_frames(input int n, input int budget);
    int i = 0;
    while (fd_q.size() < n && i < budget) begin next_cycle(); i++; end
    repeat (5) next_cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; snap = 1'b1;
    repeat (3) next_cycle();
    vectors++;
    if ({char_valid, busy, frame_done} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_flags got valid/busy/done=%b want 000", {char_valid, busy, frame_done});
    end
    vectors++;
    if ({char_data, char_addr} !== 13'h0) begin
      miscompares++;
      $display("FAIL reset_bus got data=%h addr=%0d want 00/0", char_data, char_addr);
    end
    vectors++;
    if (dut0.r_snap_wb !== 16'h2D2D) begin
      miscompares++;
      $display("FAIL reset_snapshot got %h want 2d2d", dut0.r_snap_wb);
    end
    snap = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    clear_obs();
    repeat (200) next_cycle();
    vectors++;
    if (val_q.size() != 0 || fd_q.size() != 0) begin
      miscompares++;
      $display("FAIL idle_no_trigger got beats=%0d done=%0d want 0/0", val_q.size(), fd_q.size());
    end
  endtask

  task automatic test_basic_frame();
    int unsigned c;
    beat_t b;
    logic [12:0] e;
    clear_obs();
    type_if = 16'h3031; type_id = 16'h3032; type_ex = 16'h3038;
    type_mem = 16'h3131; type_wb = 16'h7878;
    char_ready = 1'b1;
    push_frame(type_if, type_id, type_ex, type_mem, type_wb);
    next_cycle();
    snap = 1'b1; c = cyc;
    next_cycle();
    snap = 1'b0;
    wait_frames(1, 200);
    vectors++;
    if (obs_q.size() == 0 || obs_q[0].cyc !== c + 1) begin
      miscompares++;
      $display("FAIL basic_latency got first_beat_cyc=%0d want %0d",
               (obs_q.size() > 0) ? obs_q[0].cyc : 0, c + 1);
    end
    vectors++;
    if (obs_q.size() != 20) begin
      miscompares++;
      $display("FAIL basic_count got %0d beats want 20", obs_q.size());
    end
    vectors++;
    if (fd_q.size() != 1 || obs_q.size() == 0 || fd_q[0] !== obs_q[$].cyc + 1) begin
      miscompares++;
      $display("FAIL basic_done got pulses=%0d want 1 pulse right after last beat", fd_q.size());
    end
    while (obs_q.size() > 0 && sb_q.size() > 0) begin
      b = obs_q.pop_front(); e = sb_q.pop_front();
      vectors++;
      if ({b.addr, b.data} !== e) begin
        miscompares++;
        $display("FAIL basic_beat got addr=%0d data=%h want addr=%0d data=%h",
                 b.addr, b.data, e[12:8], e[7:0]);
      end
    end
  endtask

  task automatic test_backpressure();
    int i = 0;
    beat_t b;
    logic [12:0] e;
    clear_obs();
    push_frame(type_if, type_id, type_ex, type_mem, type_wb);
    while (fd_q.size() < 1 && i < 400) begin
      next_cycle();
      char_ready = (i % 4 == 0) || (i % 4 == 3);
      snap = (i == 0);
      i++;
    end
    snap = 1'b0; char_ready = 1'b1;
    repeat (5) next_cycle();
    for (int j = 0; j + 1 < val_q.size(); j++) begin
      if (!val_q[j].rdy) begin
        vectors++;
        if ({val_q[j+1].addr, val_q[j+1].data} !== {val_q[j].addr, val_q[j].data}) begin
          miscompares++;
          $display("FAIL bp_hold got addr=%0d data=%h want addr=%0d data=%h",
                   val_q[j+1].addr, val_q[j+1].data, val_q[j].addr, val_q[j].data);
        end
      end
    end
    vectors++;
    if (obs_q.size() != 20) begin
      miscompares++;
      $display("FAIL bp_count got %0d beats want 20", obs_q.size());
    end
    while (obs_q.size() > 0 && sb_q.size() > 0) begin
      b = obs_q.pop_front(); e = sb_q.pop_front();
      vectors++;
      if ({b.addr, b.data} !== e) begin
        miscompares++;
        $display("FAIL bp_beat got addr=%0d data=%h want addr=%0d data=%h",
                 b.addr, b.data, e[12:8], e[7:0]);
      end
    end
  endtask

  task automatic test_pending_collapse();
    int i = 0;
    logic f5 = 1'b0, f12 = 1'b0;
    beat_t b;
    logic [12:0] e;
    clear_obs();
    char_ready = 1'b1;
    push_frame(type_if, type_id, type_ex, type_mem, type_wb);
    push_frame(type_if, type_id, type_ex, type_mem, type_wb);
    while (fd_q.size() < 2 && i < 300) begin
      next_cycle();
      snap = 1'b0;
      if (i == 0) snap = 1'b1;
      if (char_valid && char_addr == 5'd5 && !f5) begin snap = 1'b1; f5 = 1'b1; end
      if (char_valid && char_addr == 5'd12 && !f12) begin snap = 1'b1; f12 = 1'b1; end
      i++;
    end
    snap = 1'b0;
    repeat (30) next_cycle();
    vectors++;
    if (fd_q.size() != 2 || obs_q.size() != 40) begin
      miscompares++;
      $display("FAIL pend_frames got done=%0d beats=%0d want 2/40", fd_q.size(), obs_q.size());
    end
    vectors++;
    if (fd_q.size() < 1 || obs_q.size() < 21 || obs_q[20].cyc !== fd_q[0] + 2) begin
      miscompares++;
      $display("FAIL pend_restart got cyc=%0d want %0d",
               (obs_q.size() > 20) ? obs_q[20].cyc : 0, (fd_q.size() > 0) ? fd_q[0] + 2 : 0);
    end
    while (obs_q.size() > 0 && sb_q.size() > 0) begin
      b = obs_q.pop_front(); e = sb_q.pop_front();
      vectors++;
      if ({b.addr, b.data} !== e) begin
        miscompares++;
        $display("FAIL pend_beat got addr=%0d data=%h want addr=%0d data=%h",
                 b.addr, b.data, e[12:8], e[7:0]);
      end
    end
  endtask

  task automatic test_snapshot_isolation();
    int i = 0;
    beat_t b;
    logic [12:0] e;
    clear_obs();
    char_ready = 1'b1;
    push_frame(type_if, type_id, 16'h3038, type_mem, type_wb);
    while (fd_q.size() < 1 && i < 200) begin
      next_cycle();
      snap = (i == 0);
      if (char_valid && char_addr == 5'd3) type_ex = 16'h3044;
      i++;
    end
    snap = 1'b0;
    push_frame(type_if, type_id, 16'h3044, type_mem, type_wb);
    next_cycle(); snap = 1'b1;
    next_cycle(); snap = 1'b0;
    wait_frames(2, 200);
    vectors++;
    if (obs_q.size() != 40) begin
      miscompares++;
      $display("FAIL iso_count got %0d beats want 40", obs_q.size());
    end
    while (obs_q.size() > 0 && sb_q.size() > 0) begin
      b = obs_q.pop_front(); e = sb_q.pop_front();
      vectors++;
      if ({b.addr, b.data} !== e) begin
        miscompares++;
        $display("FAIL iso_beat got addr=%0d data=%h want addr=%0d data=%h",
                 b.addr, b.data, e[12:8], e[7:0]);
      end
    end
  endtask

  task automatic test_refresh();
    logic found;
    st64_q.delete(); fd64_q.delete();
    char_ready = 1'b1; snap = 1'b0;
    repeat (64 * 5 + 10) next_cycle();
    vectors++;
    if (st64_q.size() < 4) begin
      miscompares++;
      $display("FAIL refresh_count got %0d frames want >=4", st64_q.size());
    end
    for (int i = 2; i < st64_q.size(); i++) begin
      vectors++;
      if (st64_q[i].cyc - st64_q[i-1].cyc !== 32'd64) begin
        miscompares++;
        $display("FAIL refresh_period got %0d want 64", st64_q[i].cyc - st64_q[i-1].cyc);
      end
    end
    for (int i = 1; i < st64_q.size(); i++) begin
      vectors++;
      if ({st64_q[i].bsy, st64_q[i].addr, st64_q[i].data} !== {1'b1, 5'd0, 8'h46}) begin
        miscompares++;
        $display("FAIL refresh_first got busy=%b addr=%0d data=%h want 1/0/46",
                 st64_q[i].bsy, st64_q[i].addr, st64_q[i].data);
      end
      if (st64_q[i].cyc + 20 < cyc - 5) begin
        found = 1'b0;
        foreach (fd64_q[k]) if (fd64_q[k] == st64_q[i].cyc + 20) found = 1'b1;
        vectors++;
        if (!found) begin
          miscompares++;
          $display("FAIL refresh_done got no pulse want pulse at cyc %0d", st64_q[i].cyc + 20);
        end
      end
    end
  endtask

  task automatic test_abort();
    int i = 0;
    clear_obs();
    char_ready = 1'b1;
    next_cycle(); snap = 1'b1;
    next_cycle(); snap = 1'b0;
    while (!(char_valid && char_addr == 5'd10) && i < 100) begin next_cycle(); i++; end
    vectors++;
    if (!(char_valid && char_addr == 5'd10)) begin
      miscompares++;
      $display("FAIL abort_reach got addr=%0d want 10", char_addr);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({char_valid, busy, frame_done, char_data, char_addr} !== 16'h0) begin
      miscompares++;
      $display("FAIL abort_async got valid=%b busy=%b done=%b data=%h addr=%0d want all 0",
               char_valid, busy, frame_done, char_data, char_addr);
    end
    vectors++;
    if (dut0.r_snap_ex !== 16'h2D2D) begin
      miscompares++;
      $display("FAIL abort_snapshot got %h want 2d2d", dut0.r_snap_ex);
    end
    fd_q.delete(); val_q.delete();
    repeat (2) next_cycle();
    rst_n = 1'b1;
    repeat (40) next_cycle();
    vectors++;
    if (fd_q.size() != 0 || val_q.size() != 0) begin
      miscompares++;
      $display("FAIL abort_quiet got done=%0d beats=%0d want 0/0", fd_q.size(), val_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_pending_collapse();
    test_snapshot_isolation();
    test_refresh();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
